// File: rtl/alu_exec.sv
// Execute/write-back stage behind the 4x8 register group: single-cycle ALU ops
// plus a WIDTH-cycle shift-add multiply, with registered result, flags and write strobe.
module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic [1:0]       dst_in,
    output logic [WIDTH-1:0] i,
    output logic             we,
    output logic [1:0]       wr_sel,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int M  = WIDTH - 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_p0, b_p0;
    logic [2:0]         op_p0;
    logic [1:0]         dst_p0;
    logic [2*WIDTH-1:0] acc_p1, acc_sum;
    logic [CW-1:0]      cnt_p1;
    logic               mul_last;

    // Returns {N,Z,C,V,result} for every op except MUL.
    function automatic logic [WIDTH+3:0] alu_calc(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] r;
        logic             c, v;
        ext = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (f)
            3'b000: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[M:0];
                c   = ext[WIDTH];
                v   = (a[M] == b[M]) && (r[M] != a[M]);
            end
            3'b001: begin
                ext = {1'b0, a} - {1'b0, b};
                r   = ext[M:0];
                c   = ext[WIDTH];
                v   = (a[M] != b[M]) && (r[M] != a[M]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = ~b;
            3'b110: begin
                r = {a[M-1:0], 1'b0};
                c = a[M];
            end
            default: r = '0;
        endcase
        return {r[M], (r == '0), c, v, r};
    endfunction

    // Low half is the result; a non-zero high half reports as carry.
    function automatic logic [WIDTH+3:0] mul_flags(input logic [2*WIDTH-1:0] p);
        logic [WIDTH-1:0] lo;
        lo = p[M:0];
        return {lo[M], (lo == '0), (p[2*WIDTH-1:WIDTH] != '0), 1'b0, lo};
    endfunction

    assign acc_sum  = acc_p1 + (b_p0[cnt_p1] ? ({{WIDTH{1'b0}}, a_p0} << cnt_p1) : '0);
    assign mul_last = (cnt_p1 == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign we   = (state == WB);
    assign done = (state == WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (op == 3'b111) ? MUL : EXEC;
            EXEC:    state_nx = WB;
            MUL:     if (mul_last) state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture at accept, then compute / accumulate into the result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0   <= '0;
            b_p0   <= '0;
            op_p0  <= '0;
            dst_p0 <= '0;
            acc_p1 <= '0;
            cnt_p1 <= '0;
            i      <= '0;
            flags  <= '0;
            wr_sel <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_p0   <= d_in;
                    b_p0   <= s_in;
                    op_p0  <= op;
                    dst_p0 <= dst_in;
                    acc_p1 <= '0;
                    cnt_p1 <= '0;
                end
                EXEC: begin
                    {flags, i} <= alu_calc(op_p0, a_p0, b_p0);
                    wr_sel     <= dst_p0;
                end
                MUL: begin
                    acc_p1 <= acc_sum;
                    cnt_p1 <= cnt_p1 + 1'b1;
                    if (mul_last) begin
                        {flags, i} <= mul_flags(acc_sum);
                        wr_sel     <= dst_p0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
